// File: rtl/spram_rr_arbiter_if.sv
// Requester-side bus of the shared single-port RAM arbiter.
// The master side belongs to the engines, and the slave side belongs to the arbiter.
interface spram_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/spram_rr_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM (active-low CEB/WEB) and returns read data one cycle after the grant.
// Define SPRAM_INIT_CLEAR_EN to zero-fill the whole RAM after every reset before requesters are admitted.
module spram_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  spram_rr_arbiter_if.slave     req_if,
  output logic                  ram_ceb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_if.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_if.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic                  run_en;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SPRAM_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    run_en  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          init_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) state_d = ST_RUN;
        end
        ST_RUN:  run_en = 1'b1;
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign init_addr = cnt_q;
`else
  assign run_en    = ~rst;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_id;
  logic             any_valid;
  logic             gnt;

  // The scan runs from the farthest offset down, so the requester closest to ptr wins.
  always_comb begin
    any_valid = 1'b0;
    gnt_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_if.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        any_valid = 1'b1;
        gnt_id    = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign gnt   = any_valid & run_en;
  assign ptr_d = gnt ? PTR_W'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;

  logic                  rd_pend_q;
  logic [PTR_W-1:0]      rd_id_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;

  always_comb begin
    ready = '0;
    if (gnt) ready[gnt_id] = 1'b1;
  end

  // A response that is pending when reset is asserted is discarded.
  always_comb begin
    rsp_vld = '0;
    if (rd_pend_q && !rst) rsp_vld[rd_id_q] = 1'b1;
  end

  assign rsp_data = rst ? '0 : (rd_pend_q ? ram_q : rdata_q);

  always_comb begin
    ram_ceb = 1'b1;
    ram_web = 1'b1;
    ram_a   = a_q;
    ram_d   = d_q;
    if (init_wr) begin
      ram_ceb = 1'b0;
      ram_web = 1'b0;
      ram_a   = init_addr;
      ram_d   = '0;
    end else if (gnt) begin
      ram_ceb = 1'b0;
      ram_web = ~req_if.req_we[gnt_id];
      ram_a   = addr_arr[gnt_id];
      ram_d   = wdata_arr[gnt_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
      rdata_q   <= '0;
      a_q       <= '0;
      d_q       <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= gnt & ~req_if.req_we[gnt_id];
      if (gnt) rd_id_q <= gnt_id;
      rdata_q   <= rsp_data;
      if (!ram_ceb) begin
        a_q <= ram_a;
        d_q <= ram_d;
      end
    end
  end

  assign req_if.req_ready = ready;
  assign req_if.rsp_valid = rsp_vld;
  assign req_if.rsp_rdata = rsp_data;
  assign req_if.init_done = run_en;

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural single-port RAM (write-commit / read-data on the CLK edge).
// Inputs are driven 1 time unit after posedge, and outputs are sampled on negedge.
module tb_spram_rr_arbiter;
  logic        clk;
  logic        rst;
  logic        ram_ceb;
  logic        ram_web;
  logic [4:0]  ram_a;
  logic [31:0] ram_d;
  logic [31:0] ram_q;
  logic [31:0] mem [32];

  int n_cmp;
  int n_bad;

  spram_rr_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  spram_rr_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_if  (bus.slave),
    .ram_ceb (ram_ceb),
    .ram_web (ram_web),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_q   (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_ceb) begin
      if (!ram_web) mem[ram_a] <= ram_d;
      else          ram_q <= mem[ram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*5 +: 5]    = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
    check_eq({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'h0);
    check_eq({tag, "_ready"},     64'(bus.req_ready), 64'h0);
    check_eq({tag, "_ceb"},       64'(ram_ceb),       64'h1);
    check_eq({tag, "_web"},       64'(ram_web),       64'h1);
    check_eq({tag, "_init_done"}, 64'(bus.init_done), 64'h0);
  endtask

  // Deassert reset at the current drive point, then check the start-up phase; this task ends at a sample point.
  task automatic release_and_init();
    rst = 1'b0;
`ifdef SPRAM_INIT_CLEAR_EN
    set_req(0, 1'b1, 1'b0, 5'd3, 32'h0);
    for (int i = 0; i < 32; i++) begin
      to_sample();
      check_eq($sformatf("init%0d_ceb", i), 64'(ram_ceb), 64'h0);
      check_eq($sformatf("init%0d_web", i), 64'(ram_web), 64'h0);
      check_eq($sformatf("init%0d_a", i), 64'(ram_a), 64'(i));
      check_eq($sformatf("init%0d_d", i), 64'(ram_d), 64'h0);
      check_eq($sformatf("init%0d_ready", i), 64'(bus.req_ready), 64'h0);
      check_eq($sformatf("init%0d_done", i), 64'(bus.init_done), 64'h0);
      check_eq($sformatf("init%0d_rsp", i), 64'(bus.rsp_valid), 64'h0);
      to_drive();
    end
    clear_reqs();
    to_sample();
    check_eq("init_done_after_fill", 64'(bus.init_done), 64'h1);
`else
    to_sample();
    check_eq("init_done_first_cycle", 64'(bus.init_done), 64'h1);
    check_eq("post_rst_rsp", 64'(bus.rsp_valid), 64'h0);
    check_eq("post_rst_ready", 64'(bus.req_ready), 64'h0);
    check_eq("post_rst_ceb", 64'(ram_ceb), 64'h1);
`endif
  endtask

  logic [1:0] fair_exp [8];
  int deny;
  int max_deny;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1;
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 5'd7, 32'h1);
    set_req(1, 1'b1, 1'b0, 5'd8, 32'h2);

    // Reset state, with requests held active to prove that ready is held low.
    to_drive();
    to_drive();
    to_sample();
    check_reset_vals("reset");
    to_drive();
    clear_reqs();
    release_and_init();

    // Read after write on requester 0.
    to_drive();
    set_req(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    to_sample();
    check_eq("raw_wr_ready", 64'(bus.req_ready), 64'h1);
    check_eq("raw_wr_ceb", 64'(ram_ceb), 64'h0);
    check_eq("raw_wr_web", 64'(ram_web), 64'h0);
    check_eq("raw_wr_a", 64'(ram_a), 64'h5);
    check_eq("raw_wr_d", 64'(ram_d), 64'hDEADBEEF);
    to_drive();
    set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
    to_sample();
    check_eq("raw_rd_ready", 64'(bus.req_ready), 64'h1);
    check_eq("raw_rd_ceb", 64'(ram_ceb), 64'h0);
    check_eq("raw_rd_web", 64'(ram_web), 64'h1);
    check_eq("raw_wr_no_rsp", 64'(bus.rsp_valid), 64'h0);
    to_drive();
    clear_reqs();
    to_sample();
    check_eq("raw_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check_eq("raw_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);

    // Idle cycles: the RAM is disabled, the address is held, and the read data is held.
    for (int k = 0; k < 3; k++) begin
      to_drive();
      to_sample();
      check_eq($sformatf("idle%0d_ceb", k), 64'(ram_ceb), 64'h1);
      check_eq($sformatf("idle%0d_web", k), 64'(ram_web), 64'h1);
      check_eq($sformatf("idle%0d_ready", k), 64'(bus.req_ready), 64'h0);
      check_eq($sformatf("idle%0d_a_hold", k), 64'(ram_a), 64'h5);
      check_eq($sformatf("idle%0d_rsp", k), 64'(bus.rsp_valid), 64'h0);
      check_eq($sformatf("idle%0d_rdata_hold", k), 64'(bus.rsp_rdata), 64'hDEADBEEF);
    end
    // The pointer stays at 1 across the idle cycles, so requester 1 wins.
    to_drive();
    set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
    set_req(1, 1'b1, 1'b0, 5'd5, 32'h0);
    to_sample();
    check_eq("idle_ptr_kept", 64'(bus.req_ready), 64'h2);
    to_drive();
    bus.req_valid[0] = 1'b0;
    to_sample();
    check_eq("single_req1_ready", 64'(bus.req_ready), 64'h2);
    check_eq("single_req1_prev_rsp", 64'(bus.rsp_valid), 64'h2);
    check_eq("single_req1_prev_data", 64'(bus.rsp_rdata), 64'hDEADBEEF);

    // Fairness: requester 1 is always valid, and requester 0 pulses on even cycles.
    deny = 0;
    max_deny = 0;
    for (int i = 0; i < 8; i++) begin
      to_drive();
      bus.req_valid[0] = (i % 2 == 0);
      bus.req_valid[1] = 1'b1;
      to_sample();
      check_eq($sformatf("fair%0d_ready", i), 64'(bus.req_ready), 64'(fair_exp[i]));
      check_eq($sformatf("fair%0d_rsp", i), 64'(bus.rsp_valid), 64'((i == 0) ? 2'b10 : fair_exp[i-1]));
      check_eq($sformatf("fair%0d_rdata", i), 64'(bus.rsp_rdata), 64'hDEADBEEF);
      if (bus.req_ready[1]) deny = 0;
      else                  deny++;
      if (deny > max_deny) max_deny = deny;
    end
    check_eq("fair_max_deny", 64'(max_deny), 64'h1);
    to_drive();
    clear_reqs();
    to_sample();
    check_eq("fair_last_rsp", 64'(bus.rsp_valid), 64'h2);

    // Reset is asserted in the cycle after a read grant, so the response is discarded.
    to_drive();
    set_req(0, 1'b1, 1'b0, 5'd5, 32'h0);
    to_sample();
    check_eq("rstrd_grant", 64'(bus.req_ready), 64'h1);
    to_drive();
    rst = 1'b1;
    clear_reqs();
    to_sample();
    check_reset_vals("rstrd_cyc0");
    to_drive();
    to_sample();
    check_reset_vals("rstrd_cyc1");
    to_drive();
    release_and_init();

    // Contention after reset: two writes leave the pointer at 0, then both requesters read.
    to_drive();
    set_req(0, 1'b1, 1'b1, 5'd1, 32'h11111111);
    to_sample();
    check_eq("cont_wr0_ready", 64'(bus.req_ready), 64'h1);
    check_eq("cont_wr0_a", 64'(ram_a), 64'h1);
    to_drive();
    clear_reqs();
    set_req(1, 1'b1, 1'b1, 5'd2, 32'h22222222);
    to_sample();
    check_eq("cont_wr1_ready", 64'(bus.req_ready), 64'h2);
    check_eq("cont_wr1_a", 64'(ram_a), 64'h2);
    check_eq("cont_wr1_d", 64'(ram_d), 64'h22222222);
    to_drive();
    set_req(0, 1'b1, 1'b0, 5'd1, 32'h0);
    set_req(1, 1'b1, 1'b0, 5'd2, 32'h0);
    for (int c = 0; c < 4; c++) begin
      to_sample();
      check_eq($sformatf("cont%0d_ready", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) begin
        check_eq($sformatf("cont%0d_rsp", c), 64'(bus.rsp_valid), ((c - 1) % 2 == 0) ? 64'h1 : 64'h2);
        check_eq($sformatf("cont%0d_rdata", c), 64'(bus.rsp_rdata),
                 ((c - 1) % 2 == 0) ? 64'h11111111 : 64'h22222222);
      end
      to_drive();
    end
    clear_reqs();
    to_sample();
    check_eq("cont_last_rsp", 64'(bus.rsp_valid), 64'h2);
    check_eq("cont_last_rdata", 64'(bus.rsp_rdata), 64'h22222222);

`ifdef SPRAM_INIT_CLEAR_EN
    // The initial fill has cleared the top word.
    to_drive();
    set_req(0, 1'b1, 1'b0, 5'd31, 32'h0);
    to_sample();
    check_eq("clr_rd_ready", 64'(bus.req_ready), 64'h1);
    to_drive();
    clear_reqs();
    to_sample();
    check_eq("clr_rd_rsp", 64'(bus.rsp_valid), 64'h1);
    check_eq("clr_rd_rdata", 64'(bus.rsp_rdata), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
